rvm_mem_responder: RTL and testbench



---
 rtl/rvm_mem_responder_pkg.sv | 34 +++
 rtl/rvm_mem_array.sv | 48 ++++
 rtl/rvm_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_rvm_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rvm_mem_responder_pkg.sv
// Shared definitions for the memory-bus responder.
//   - rvm_mem_fsm_e      : responder FSM state encoding (IDLE/WAIT/RESP)
//   - RVM_MEM_WAIT_W     : width of the wait-state counter
//   - RVM_MEM_BEN_NONE   : "no byte lane selected" value of mem_b_en
//   - rvm_mem_fault()    : access-fault check for one request
package rvm_mem_responder_pkg;

    typedef enum logic [1:0] {
        RVM_MEM_FSM_IDLE = 2'd0,
        RVM_MEM_FSM_WAIT = 2'd1,
        RVM_MEM_FSM_RESP = 2'd2
    } rvm_mem_fsm_e;

    localparam int          RVM_MEM_WAIT_W   = 4;
    localparam logic [3:0]  RVM_MEM_BEN_NONE = 4'b0000;

    // A request faults when it is misaligned, below the window, past the
    // end of the window, or selects no byte lane. span is the window size in
    // bytes and is 33 bits wide so a window covering 4 GiB still compares.
    function automatic logic rvm_mem_fault(
        input logic [31:0] addr,
        input logic [3:0]  b_en,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [31:0] off;
        off = addr - base;
        rvm_mem_fault = (addr[1:0] != 2'b00)
                     || (addr < base)
                     || ({1'b0, off} >= span)
                     || (b_en == RVM_MEM_BEN_NONE);
    endfunction

endpackage

// File: rtl/rvm_mem_array.sv
// DEPTH x 32-bit single-port synchronous RAM with byte-lane writes.
//   clk     : clock
//   resetn  : synchronous active-low reset (clears the read register only)
//   rd_en   : load rdata with mem[idx] at this edge; otherwise rdata -> 0
//   wr_en   : per-lane write enables, lane n <-> wdata[8n+7:8n]
//   idx     : word index shared by read and write
//   wdata   : write data
//   rdata   : registered read data (old word when read and write coincide)
module rvm_mem_array #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rd_en,
    input  logic [3:0]       wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Byte-lane write port; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register: holds a word only in the cycle after rd_en, else zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rvm_mem_responder.sv
// Memory-side responder for the core's memory bus.
//   clk, resetn : clock, synchronous active-low reset
//   mem_c_en    : request valid, held until the response cycle
//   mem_w_en    : 1 = write, 0 = read
//   mem_addr    : byte address
//   mem_b_en    : byte-lane enables
//   mem_wdata   : write data
//   mem_rdata   : read data (pre-write word on writes), response cycle only
//   mem_error   : access fault, response cycle only
//   mem_stall   : 1 = hold request; 0 with mem_c_en = transfer completes
// A request is latched in IDLE, waits WAIT_CYCLES cycles in WAIT and is
// answered in RESP. Writes commit at the end of RESP.
module rvm_mem_responder
    import rvm_mem_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_c_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_b_en,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [RVM_MEM_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? 4'd0 : RVM_MEM_WAIT_W'(WAIT_CYCLES - 1);

    rvm_mem_fsm_e               state_r, state_s;
    logic [RVM_MEM_WAIT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]                addr_r;
    logic                       w_en_r;
    logic [3:0]                 b_en_r;
    logic [31:0]                wdata_r;
    logic                       fault_r;
    logic                       error_r;

    logic                       accept_s;
    logic                       fault_in_s;
    logic                       fault_now_s;
    logic [31:0]                off_s;
    logic [IDX_W-1:0]           idx_s;
    logic                       enter_resp_s;
    logic                       rd_en_s;
    logic [3:0]                 wr_en_s;
    logic                       unused_s;

    assign accept_s   = (state_r == RVM_MEM_FSM_IDLE) && mem_c_en;
    assign fault_in_s = rvm_mem_fault(mem_addr, mem_b_en, BASE_ADDR, SPAN);

    // In IDLE the request is still on the bus (needed when WAIT_CYCLES=0);
    // afterwards only the latched copy is used.
    always_comb begin
        if (state_r == RVM_MEM_FSM_IDLE) begin
            off_s       = mem_addr - BASE_ADDR;
            fault_now_s = fault_in_s;
        end else begin
            off_s       = addr_r - BASE_ADDR;
            fault_now_s = fault_r;
        end
    end

    assign idx_s    = off_s[IDX_W+1:2];
    assign unused_s = ^{off_s[31:IDX_W+2], off_s[1:0]};

    // Next-state and wait counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            RVM_MEM_FSM_IDLE: begin
                if (mem_c_en) begin
                    if (WAIT_CYCLES == 0) begin
                        state_s = RVM_MEM_FSM_RESP;
                    end else begin
                        state_s = RVM_MEM_FSM_WAIT;
                        cnt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_s = RVM_MEM_FSM_IDLE;
                end
            end
            RVM_MEM_FSM_WAIT: begin
                if (!mem_c_en) begin
                    state_s = RVM_MEM_FSM_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_s = RVM_MEM_FSM_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RVM_MEM_FSM_RESP: begin
                state_s = RVM_MEM_FSM_IDLE;
            end
            default: begin
                state_s = RVM_MEM_FSM_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // The RAM read is issued on the edge into RESP so the word is in the
    // read register during RESP; a later write to the same word therefore
    // returns the pre-write value.
    assign enter_resp_s = (state_s == RVM_MEM_FSM_RESP) && (state_r != RVM_MEM_FSM_RESP);
    assign rd_en_s      = enter_resp_s && !fault_now_s;

    // Write commits at the end of RESP; resetn gates it because the array
    // itself has no reset.
    always_comb begin
        if ((state_r == RVM_MEM_FSM_RESP) && w_en_r && mem_c_en && !fault_r && resetn) begin
            wr_en_s = b_en_r;
        end else begin
            wr_en_s = 4'b0000;
        end
    end

    assign mem_stall = accept_s || (state_r == RVM_MEM_FSM_WAIT);
    assign mem_error = error_r;

    // State, counter, request latch and error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= RVM_MEM_FSM_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'h0000_0000;
            w_en_r  <= 1'b0;
            b_en_r  <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            fault_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r  <= mem_addr;
                w_en_r  <= mem_w_en;
                b_en_r  <= mem_b_en;
                wdata_r <= mem_wdata;
                fault_r <= fault_in_s;
            end
            error_r <= enter_resp_s && fault_now_s;
        end
    end

    rvm_mem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk    (clk),
        .resetn (resetn),
        .rd_en  (rd_en_s),
        .wr_en  (wr_en_s),
        .idx    (idx_s),
        .wdata  (wdata_r),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Directed bench: one responder with two wait states (a_*) and one with
// none (b_*), both 16 words deep at base address 0.
module tb_rvm_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_c_en, a_w_en, a_err, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_ben;
    logic        b_rstn, b_c_en, b_w_en, b_err, b_stall;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_ben;

    int n_cmp = 0;
    int n_bad = 0;

    rvm_mem_responder #(
        .DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2), .INIT_FILE("")
    ) dut_w2 (
        .clk(clk), .resetn(a_rstn), .mem_c_en(a_c_en), .mem_w_en(a_w_en),
        .mem_addr(a_addr), .mem_b_en(a_ben), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .mem_error(a_err), .mem_stall(a_stall)
    );

    rvm_mem_responder #(
        .DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0), .INIT_FILE("")
    ) dut_w0 (
        .clk(clk), .resetn(b_rstn), .mem_c_en(b_c_en), .mem_w_en(b_w_en),
        .mem_addr(b_addr), .mem_b_en(b_ben), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .mem_error(b_err), .mem_stall(b_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full access on the two-wait-state responder. Request fields are
    // scrambled after acceptance to show only the latched copy matters.
    task automatic acc2(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic chk_rd);
        @(posedge clk); #1;
        a_c_en = 1'b1; a_w_en = w; a_addr = a; a_ben = be; a_wdata = wd;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("a_stall_wait", {31'd0, a_stall}, 32'd1);
            check_eq("a_err_wait",   {31'd0, a_err},   32'd0);
            @(posedge clk); #1;
            if (i == 0) begin
                a_addr = a ^ 32'h0000_0024; a_ben = ~be; a_wdata = ~wd;
            end
        end
        @(negedge clk);
        check_eq("a_stall_resp", {31'd0, a_stall}, 32'd0);
        check_eq("a_err_resp",   {31'd0, a_err},   {31'd0, exp_err});
        if (chk_rd) check_eq("a_rdata_resp", a_rdata, exp_rd);
        @(posedge clk); #1;
        a_c_en = 1'b0;
        @(negedge clk);
        check_eq("a_rdata_idle", a_rdata, 32'd0);
        check_eq("a_err_idle",   {31'd0, a_err}, 32'd0);
    endtask

    // Access on the zero-wait responder; c_en is left as is so calls chain
    // back-to-back. drop releases c_en during the response cycle.
    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic chk_rd, input logic drop);
        @(posedge clk); #1;
        b_c_en = 1'b1; b_w_en = w; b_addr = a; b_ben = 4'hF; b_wdata = wd;
        @(negedge clk);
        check_eq("b_stall_req", {31'd0, b_stall}, 32'd1);
        @(posedge clk); #1;
        if (drop) b_c_en = 1'b0;
        @(negedge clk);
        check_eq("b_stall_resp", {31'd0, b_stall}, 32'd0);
        check_eq("b_err_resp",   {31'd0, b_err},   32'd0);
        if (chk_rd) check_eq("b_rdata_resp", b_rdata, exp_rd);
    endtask

    // Apply resetn for one cycle n cycles after a request is accepted.
    task automatic rst_mid(input logic w, input logic [31:0] a, input logic [31:0] wd, input int n);
        @(posedge clk); #1;
        a_c_en = 1'b1; a_w_en = w; a_addr = a; a_ben = 4'hF; a_wdata = wd;
        repeat (n) begin @(posedge clk); #1; end
        a_rstn = 1'b0;
        @(posedge clk); #1;
        a_rstn = 1'b1; a_c_en = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", {31'd0, a_stall}, 32'd0);
        check_eq("rst_err",   {31'd0, a_err},   32'd0);
        check_eq("rst_rdata", a_rdata, 32'd0);
    endtask

    initial begin
        a_rstn = 1'b0; a_c_en = 1'b0; a_w_en = 1'b0; a_addr = 32'd0; a_ben = 4'd0; a_wdata = 32'd0;
        b_rstn = 1'b0; b_c_en = 1'b0; b_w_en = 1'b0; b_addr = 32'd0; b_ben = 4'd0; b_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1; a_rstn = 1'b1; b_rstn = 1'b1;
        @(negedge clk);
        check_eq("reset_a_stall", {31'd0, a_stall}, 32'd0);
        check_eq("reset_a_err",   {31'd0, a_err},   32'd0);
        check_eq("reset_a_rdata", a_rdata, 32'd0);
        check_eq("reset_b_stall", {31'd0, b_stall}, 32'd0);
        check_eq("reset_b_err",   {31'd0, b_err},   32'd0);
        check_eq("reset_b_rdata", b_rdata, 32'd0);

        // Plain read with two wait states.
        acc2(1'b1, 32'h0C, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        acc2(1'b0, 32'h0C, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        // Single-lane write, old word returned.
        acc2(1'b1, 32'h10, 4'hF, 32'h11223344, 32'd0, 1'b0, 1'b0);
        acc2(1'b1, 32'h10, 4'b0010, 32'h0000AB00, 32'h11223344, 1'b0, 1'b1);
        acc2(1'b0, 32'h10, 4'hF, 32'd0, 32'h1122AB44, 1'b0, 1'b1);
        // Faults: misaligned, one past the end (aliases word 0), no lanes.
        acc2(1'b1, 32'h04, 4'hF, 32'h55667788, 32'd0, 1'b0, 1'b0);
        acc2(1'b1, 32'h00, 4'hF, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
        acc2(1'b1, 32'h06, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1);
        acc2(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1);
        acc2(1'b0, 32'h0C, 4'h0, 32'd0, 32'd0, 1'b1, 1'b1);
        acc2(1'b0, 32'h04, 4'hF, 32'd0, 32'h55667788, 1'b0, 1'b1);
        acc2(1'b0, 32'h00, 4'hF, 32'd0, 32'hA5A5A5A5, 1'b0, 1'b1);
        // Last word of the window is legal.
        acc2(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
        acc2(1'b0, 32'h3C, 4'hF, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);

        // Abort a write during WAIT.
        acc2(1'b1, 32'h08, 4'hF, 32'h01020304, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_c_en = 1'b1; a_w_en = 1'b1; a_addr = 32'h08; a_ben = 4'hF; a_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("abort_stall_req", {31'd0, a_stall}, 32'd1);
        @(posedge clk); #1;
        a_c_en = 1'b0;
        @(negedge clk);
        check_eq("abort_stall_wait", {31'd0, a_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("abort_stall_after", {31'd0, a_stall}, 32'd0);
        check_eq("abort_err_after",   {31'd0, a_err},   32'd0);
        check_eq("abort_rdata_after", a_rdata, 32'd0);
        acc2(1'b0, 32'h08, 4'hF, 32'd0, 32'h01020304, 1'b0, 1'b1);

        // Reset during WAIT of a read, then during RESP of a write.
        rst_mid(1'b0, 32'h0C, 32'd0, 1);
        acc2(1'b0, 32'h0C, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        rst_mid(1'b1, 32'h0C, 32'h00000000, 3);
        acc2(1'b0, 32'h0C, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Zero wait states: preload, back-to-back reads, write dropped in RESP.
        acc0(1'b1, 32'h00, 32'h0A0B0C0D, 32'd0, 1'b0, 1'b0);
        acc0(1'b1, 32'h04, 32'h10203040, 32'd0, 1'b0, 1'b0);
        acc0(1'b0, 32'h00, 32'd0, 32'h0A0B0C0D, 1'b1, 1'b0);
        acc0(1'b0, 32'h04, 32'd0, 32'h10203040, 1'b1, 1'b0);
        acc0(1'b1, 32'h04, 32'h99999999, 32'h10203040, 1'b1, 1'b1);
        acc0(1'b0, 32'h04, 32'd0, 32'h10203040, 1'b1, 1'b0);
        @(posedge clk); #1;
        b_c_en = 1'b0;
        @(negedge clk);
        check_eq("b_stall_idle", {31'd0, b_stall}, 32'd0);
        check_eq("b_rdata_idle", b_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
